ysyx_22040759_pc_redirect: RTL and testbench
============================================

// Module: ysyx_22040759_pc_redirect
// PURPOSE
//  Fetch-side PC generator and redirect consumer: owns the architectural fetch PC,
//  issues instruction fetches on a req/ack handshake, and applies taken-branch/jump
//  redirects (br_taken + target) coming back from execute. Kills in-flight and
//  buffered wrong-path fetches and pulses flush to the IF/ID and ID/EX registers.
//  Sits between instruction memory and the IF/ID pipeline register.
// PARAMETERS
//  RESET_PC   64'h0000_0000_8000_0000   first fetch address after reset release
// PORTS
//  clock        in   1   core clock, all state on rising edge
//  reset_n      in   1   asynchronous, active-low reset
//  br_taken_i   in   1   redirect request from execute (branch taken / jal / jalr)
//  br_pc_i      in   64  redirect target, valid when br_taken_i=1
//  stall_i      in   1   decode cannot accept an instruction this cycle
//  if_req_o     out  1   fetch request valid
//  if_addr_o    out  64  fetch address; stable while if_req_o=1 and if_ack_i=0
//  if_ack_i     in   1   memory accepts request and returns if_rdata_i same cycle
//  if_rdata_i   in   32  fetched instruction word
//  inst_valid_o out  1   inst_o/inst_pc_o valid for decode
//  inst_o       out  32  instruction to decode
//  inst_pc_o    out  64  PC of inst_o
//  flush_o      out  1   kill younger pipeline stages (combinational = br_taken_i in RUN/KILL)
//  misalign_o   out  1   sticky: redirect target not 4-byte aligned, fetch halted
// BEHAVIOUR
//  Reset: state=BOOT, pc=RESET_PC, if_req_o=0, inst_valid_o=0, inst_o=32'h0000_0013
//   (nop), inst_pc_o=0, misalign_o=0, flush_o=0. Reset mid-handshake abandons it.
//  States: BOOT -> RUN (1 cycle after reset release, unconditional).
//   RUN: if_req_o=1 unless the output buffer holds an undelivered inst and stall_i=1.
//   KILL: a request was outstanding at redirect; keep if_req_o=1, old address, until
//    ack; discard that data; then RUN at stored target.
//   HALT: entered on misaligned target; if_req_o=0, inst_valid_o=0 until reset.
//  Fetch: ack in cycle N -> inst_valid_o=1, inst_o=if_rdata_i, inst_pc_o=pc in N+1;
//   pc<=pc+4 (64-bit wrap, no trap). Back-to-back acks give one inst per cycle.
//  Stall: stall_i=1 with inst_valid_o=1 holds inst_o/inst_pc_o/inst_valid_o unchanged;
//   no new request issued (req dropped only when not mid-handshake; an outstanding
//   req is never withdrawn). stall_i=0 consumes the held inst.
//  Redirect (br_taken_i=1, RUN): flush_o=1 same cycle; inst_valid_o<=0 next cycle;
//   pc<=br_pc_i. If req outstanding and if_ack_i=0 -> KILL. If if_ack_i=1 same cycle
//   -> data discarded, RUN, next request at target on following cycle.
//  Redirect beats stall: buffered inst dropped even if stall_i=1.
//  Redirect in KILL: target overwritten by newest br_pc_i, remain KILL, flush_o=1.
//  br_pc_i[1:0]!=0: misalign_o<=1, flush_o=1, state HALT (target not fetched).
//  Redirect ignored in BOOT and HALT (flush_o=0).
// STRUCTURE
//  Shared define file: RESET_PC default, state encodings (BOOT/RUN/KILL/HALT),
//   NOP encoding 32'h0000_0013.
//  One sub-module natural: ysyx_22040759_ibuf (1-entry inst/pc holding register with
//   valid, load, consume, clear). FSM and PC register stay in this module.
// TESTING
//  Reset release, ack every cycle -> if_addr_o 8000_0000, _0004, _0008; inst_valid_o
//   rises 1 cycle after first ack with inst_pc_o=8000_0000.
//  stall_i=1 two cycles with inst at 8000_0004 -> outputs held, no extra ack consumed,
//   next inst 8000_0008 follows release.
//  br_taken_i=1, br_pc_i=8000_0100 while req at 8000_000C unacked, ack 2 cycles later
//   -> flush_o 1 cycle, ack data discarded, next req addr 8000_0100, no wrong-path valid.
//  br_taken_i with if_ack_i same cycle -> that inst never valid; next req 8000_0100.
//  Two redirects in KILL (8000_0200 then 8000_0300) -> first fetch after KILL at 8000_0300.
//  br_pc_i=8000_0102 -> misalign_o=1 sticky, if_req_o=0; reset_n low clears, restarts RESET_PC.

Source files
------------

// File: rtl/ysyx_22040759_pc_redirect_pkg.sv
// Shared definitions for the fetch PC generator: reset PC default,
// FSM state encodings and the NOP instruction word.
package ysyx_22040759_pc_redirect_pkg;

  localparam logic [63:0] PC_RESET_DEFAULT = 64'h0000_0000_8000_0000;
  localparam logic [31:0] INST_NOP         = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_KILL = 2'd2,
    ST_HALT = 2'd3
  } state_e;

endpackage

// File: rtl/ysyx_22040759_ibuf.sv
// One-entry holding register for the instruction handed to decode.
// Clear wins over load, load wins over consume.
module ysyx_22040759_ibuf
  import ysyx_22040759_pc_redirect_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        load_i,
  input  logic        consume_i,
  input  logic [31:0] inst_i,
  input  logic [63:0] pc_i,
  output logic        valid_o,
  output logic [31:0] inst_o,
  output logic [63:0] pc_o
);

  logic        valid_q, valid_d;
  logic [31:0] inst_q, inst_d;
  logic [63:0] pc_q, pc_d;

  // Next-state selection for the holding entry
  always_comb begin
    valid_d = valid_q;
    inst_d  = inst_q;
    pc_d    = pc_q;
    if (clear_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      inst_d  = inst_i;
      pc_d    = pc_i;
    end else if (consume_i) begin
      valid_d = 1'b0;
    end
  end

  // Entry register; reset presents a NOP at PC 0 marked invalid
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      inst_q  <= INST_NOP;
      pc_q    <= 64'd0;
    end else begin
      valid_q <= valid_d;
      inst_q  <= inst_d;
      pc_q    <= pc_d;
    end
  end

  assign valid_o = valid_q;
  assign inst_o  = inst_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/ysyx_22040759_pc_redirect.sv
// Fetch-side PC generator: owns the fetch PC, drives the req/ack fetch
// handshake, consumes taken-branch redirects from execute and kills
// wrong-path fetches (in flight or buffered).
module ysyx_22040759_pc_redirect
  import ysyx_22040759_pc_redirect_pkg::*;
#(
  parameter logic [63:0] RESET_PC = PC_RESET_DEFAULT
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        br_taken_i,
  input  logic [63:0] br_pc_i,
  input  logic        stall_i,
  output logic        if_req_o,
  output logic [63:0] if_addr_o,
  input  logic        if_ack_i,
  input  logic [31:0] if_rdata_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [63:0] inst_pc_o,
  output logic        flush_o,
  output logic        misalign_o
);

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] tgt_q, tgt_d;
  logic        pend_q, pend_d;
  logic        mis_q, mis_d;

  logic        active;
  logic        redir;
  logic        br_mis;
  logic        ack_fire;
  logic        buf_valid;
  logic        buf_load;
  logic        buf_consume;

  assign active   = (state_q == ST_RUN) || (state_q == ST_KILL);
  assign redir    = br_taken_i && active;
  assign br_mis   = (br_pc_i[1:0] != 2'b00);
  assign ack_fire = if_req_o && if_ack_i;

  // Request generation: an outstanding request is never withdrawn, and a
  // fresh one is held back only while decode stalls on a buffered inst
  always_comb begin
    if_req_o = 1'b0;
    unique case (state_q)
      ST_RUN:  if_req_o = pend_q || !(buf_valid && stall_i);
      ST_KILL: if_req_o = 1'b1;
      default: if_req_o = 1'b0;
    endcase
  end

  assign if_addr_o  = pc_q;
  assign flush_o    = redir;
  assign misalign_o = mis_q;

  // Only right-path data returned in RUN reaches decode
  assign buf_load    = (state_q == ST_RUN) && ack_fire && !br_taken_i;
  assign buf_consume = buf_valid && !stall_i;

  ysyx_22040759_ibuf u_ibuf (
    .clk_i     (clock),
    .rst_ni    (reset_n),
    .clear_i   (redir),
    .load_i    (buf_load),
    .consume_i (buf_consume),
    .inst_i    (if_rdata_i),
    .pc_i      (pc_q),
    .valid_o   (buf_valid),
    .inst_o    (inst_o),
    .pc_o      (inst_pc_o)
  );

  assign inst_valid_o = buf_valid;

  // FSM next state, PC advance and redirect target capture
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    mis_d   = mis_q;
    pend_d  = if_req_o && !if_ack_i;
    unique case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
      end
      ST_RUN, ST_KILL: begin
        if (redir) begin
          if (br_mis) begin
            state_d = ST_HALT;
            mis_d   = 1'b1;
            pend_d  = 1'b0;
          end else if (if_req_o && !if_ack_i) begin
            // Wrong-path request still open: finish it at the old address
            state_d = ST_KILL;
            tgt_d   = br_pc_i;
          end else begin
            state_d = ST_RUN;
            pc_d    = br_pc_i;
          end
        end else if (state_q == ST_KILL) begin
          if (ack_fire) begin
            state_d = ST_RUN;
            pc_d    = tgt_q;
          end
        end else if (ack_fire) begin
          pc_d = pc_q + 64'd4;
        end
      end
      default: begin
        pend_d = 1'b0;
      end
    endcase
  end

  // Control and PC state registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      tgt_q   <= 64'd0;
      pend_q  <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      pend_q  <= pend_d;
      mis_q   <= mis_d;
    end
  end

endmodule

// File: tb/tb_ysyx_22040759_pc_redirect.sv
// Self-checking bench for the fetch PC generator: directed scenarios plus
// randomized traffic against a transaction-level reference model.
module tb_ysyx_22040759_pc_redirect;

  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        br_taken_i = 1'b0;
  logic [63:0] br_pc_i = 64'd0;
  logic        stall_i = 1'b0;
  logic        if_req_o;
  logic [63:0] if_addr_o;
  logic        if_ack_i = 1'b0;
  logic [31:0] if_rdata_i = 32'd0;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [63:0] inst_pc_o;
  logic        flush_o;
  logic        misalign_o;

  ysyx_22040759_pc_redirect dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .br_taken_i   (br_taken_i),
    .br_pc_i      (br_pc_i),
    .stall_i      (stall_i),
    .if_req_o     (if_req_o),
    .if_addr_o    (if_addr_o),
    .if_ack_i     (if_ack_i),
    .if_rdata_i   (if_rdata_i),
    .inst_valid_o (inst_valid_o),
    .inst_o       (inst_o),
    .inst_pc_o    (inst_pc_o),
    .flush_o      (flush_o),
    .misalign_o   (misalign_o)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: mode 0 boot, 1 run, 2 draining a wrong-path fetch, 3 halted
  int          m_mode;
  logic [63:0] m_pc;
  logic [63:0] m_tgt;
  logic        m_out;
  logic        m_mis;
  logic [31:0] q_inst[$];
  logic [63:0] q_pc[$];

  logic [63:0] bpc_r;
  int          r;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_pc   = RST_PC;
    m_tgt  = 64'd0;
    m_out  = 1'b0;
    m_mis  = 1'b0;
    q_inst.delete();
    q_pc.delete();
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    br_taken_i = 1'b0;
    stall_i    = 1'b0;
    if_ack_i   = 1'b0;
    #1;
    check_eq("rst_req", if_req_o, 1'b0);
    check_eq("rst_valid", inst_valid_o, 1'b0);
    check_eq("rst_inst", inst_o, 32'h0000_0013);
    check_eq("rst_ipc", inst_pc_o, 64'd0);
    check_eq("rst_misal", misalign_o, 1'b0);
    check_eq("rst_flush", flush_o, 1'b0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  // One clock: drive inputs, check against the model, advance both
  task automatic step(input logic br, input logic [63:0] bpc, input logic stl,
                      input logic ack, input logic [31:0] rd);
    logic e_req, e_flush, ackf;
    e_req   = (m_mode == 1 && (m_out || !(q_inst.size() > 0 && stl))) || (m_mode == 2);
    e_flush = br && (m_mode == 1 || m_mode == 2);
    ackf    = ack && e_req;
    br_taken_i = br;
    br_pc_i    = bpc;
    stall_i    = stl;
    if_ack_i   = ackf;
    if_rdata_i = rd;
    #1;
    check_eq("req", if_req_o, e_req);
    check_eq("flush", flush_o, e_flush);
    if (e_req) check_eq("addr", if_addr_o, m_pc);
    check_eq("ivalid", inst_valid_o, q_inst.size() > 0);
    if (q_inst.size() > 0) begin
      check_eq("inst", inst_o, q_inst[0]);
      check_eq("ipc", inst_pc_o, q_pc[0]);
    end
    check_eq("misal", misalign_o, m_mis);
    @(posedge clock);
    #1;
    case (m_mode)
      0: m_mode = 1;
      3: ;
      default: begin
        if (br) begin
          q_inst.delete();
          q_pc.delete();
          if (bpc[1:0] != 2'b00) begin
            m_mode = 3;
            m_mis  = 1'b1;
          end else if (e_req && !ackf) begin
            m_mode = 2;
            m_tgt  = bpc;
          end else begin
            m_mode = 1;
            m_pc   = bpc;
          end
        end else if (m_mode == 2) begin
          if (ackf) begin
            m_mode = 1;
            m_pc   = m_tgt;
          end
        end else begin
          if (q_inst.size() > 0 && !stl) begin
            void'(q_inst.pop_front());
            void'(q_pc.pop_front());
          end
          if (ackf) begin
            q_inst.push_back(rd);
            q_pc.push_back(m_pc);
            m_pc = m_pc + 64'd4;
          end
        end
      end
    endcase
    m_out = e_req && !ackf && (m_mode != 3);
  endtask

  initial begin
    model_reset();
    do_reset();

    // Reset release with ack every cycle
    step(0, 0, 0, 0, 32'h0);
    check_eq("s1_addr0", if_addr_o, 64'h8000_0000);
    step(0, 0, 0, 1, 32'hA000_0000);
    check_eq("s1_addr1", if_addr_o, 64'h8000_0004);
    check_eq("s1_ipc0", inst_pc_o, 64'h8000_0000);
    check_eq("s1_v0", inst_valid_o, 1'b1);
    step(0, 0, 0, 1, 32'hA000_0001);
    check_eq("s1_addr2", if_addr_o, 64'h8000_0008);
    check_eq("s1_ipc1", inst_pc_o, 64'h8000_0004);

    // Stall two cycles holding the inst at 8000_0004
    step(0, 0, 1, 1, 32'hDEAD_0000);
    step(0, 0, 1, 1, 32'hDEAD_0001);
    check_eq("s2_ipc_held", inst_pc_o, 64'h8000_0004);
    check_eq("s2_inst_held", inst_o, 32'hA000_0001);
    check_eq("s2_addr_held", if_addr_o, 64'h8000_0008);
    step(0, 0, 0, 1, 32'hA000_0002);
    check_eq("s2_ipc_next", inst_pc_o, 64'h8000_0008);

    // Redirect while the request at 8000_000C is unacked
    step(0, 0, 0, 0, 32'h0);
    step(1, 64'h8000_0100, 0, 0, 32'h0);
    check_eq("s3_vkill", inst_valid_o, 1'b0);
    step(0, 0, 0, 0, 32'h0);
    step(0, 0, 0, 1, 32'hBAD0_000C);
    check_eq("s3_v_discard", inst_valid_o, 1'b0);
    check_eq("s3_addr_tgt", if_addr_o, 64'h8000_0100);
    step(0, 0, 0, 1, 32'hB000_0100);
    check_eq("s3_ipc_tgt", inst_pc_o, 64'h8000_0100);

    // Redirect together with an ack
    step(1, 64'h8000_0100, 0, 1, 32'hBAD0_0104);
    check_eq("s4_v_discard", inst_valid_o, 1'b0);
    check_eq("s4_addr_tgt", if_addr_o, 64'h8000_0100);
    step(0, 0, 0, 1, 32'hC000_0100);
    check_eq("s4_ipc_tgt", inst_pc_o, 64'h8000_0100);

    // Two redirects while draining a wrong-path fetch
    step(0, 0, 0, 0, 32'h0);
    step(1, 64'h8000_0200, 0, 0, 32'h0);
    step(1, 64'h8000_0300, 0, 0, 32'h0);
    step(0, 0, 0, 1, 32'hBAD0_0104);
    check_eq("s5_addr_tgt", if_addr_o, 64'h8000_0300);
    step(0, 0, 0, 1, 32'hD000_0300);
    check_eq("s5_ipc_tgt", inst_pc_o, 64'h8000_0300);

    // PC wraps at the top of the 64-bit space
    step(1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 1, 32'h0);
    step(0, 0, 0, 1, 32'hE000_FFFC);
    check_eq("s6_wrap_addr", if_addr_o, 64'd0);
    check_eq("s6_wrap_ipc", inst_pc_o, 64'hFFFF_FFFF_FFFF_FFFC);

    // Misaligned target halts fetch until reset
    step(1, 64'h8000_0102, 0, 1, 32'h0);
    check_eq("s7_misal", misalign_o, 1'b1);
    check_eq("s7_v", inst_valid_o, 1'b0);
    step(1, 64'h8000_0200, 0, 1, 32'h0);
    step(0, 0, 0, 1, 32'h0);
    check_eq("s7_sticky", misalign_o, 1'b1);
    do_reset();
    step(0, 0, 0, 0, 32'h0);
    check_eq("s7_restart", if_addr_o, RST_PC);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if ((m_mode == 3 && $urandom_range(0, 3) == 0) || $urandom_range(0, 299) == 0)
        do_reset();
      r = $urandom_range(0, 31);
      bpc_r = {32'h0, 32'h8000_0000 | ($urandom & 32'h0000_0FFC)};
      if (r == 0) bpc_r = bpc_r + 64'd2;
      else if (r == 1) bpc_r = 64'hFFFF_FFFF_FFFF_FFF8;
      step($urandom_range(0, 7) == 0, bpc_r, $urandom_range(0, 2) == 0,
           $urandom_range(0, 1) == 1, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
